// File: rtl/shared_reg_write_arbiter_if.sv
// Bus bundle between the requesters and shared_reg_write_arbiter.
//   req      : per-requester access request (level, held until done is seen)
//   clr_req  : per-requester select, 1 = clear the register, 0 = write wr_data
//   wr_data  : packed write data, requester i at [i*W +: W]
//   gnt      : one-hot grant, all-zero when idle
//   done     : one-cycle completion pulse to the granted requester
//   reg_ce   : clock enable to the shared register bank
//   reg_srst : synchronous reset to the shared register bank
//   reg_d    : data to the shared register bank
//   busy     : arbiter is in a transaction
//   xact_cnt : saturating count of completed transactions
// master = requester side, slave = arbiter side.
interface shared_reg_write_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 16
);
    logic [N-1:0]   req;
    logic [N-1:0]   clr_req;
    logic [N*W-1:0] wr_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           reg_ce;
    logic           reg_srst;
    logic [W-1:0]   reg_d;
    logic           busy;
    logic [CW-1:0]  xact_cnt;

    modport master (
        output req, clr_req, wr_data,
        input  gnt, done, reg_ce, reg_srst, reg_d, busy, xact_cnt
    );

    modport slave (
        input  req, clr_req, wr_data,
        output gnt, done, reg_ce, reg_srst, reg_d, busy, xact_cnt
    );
endinterface

// File: rtl/shared_reg_write_arbiter.sv
// Round-robin arbiter/sequencer giving N requesters exclusive write or clear
// access to one external W-bit register bank (D flops with ce and sync reset).
// Each transaction runs IDLE -> GRANT -> WRITE -> RELEASE; only WRITE emits a
// ce or srst strobe, so exactly one requester modifies the register per grant.
// Ports:
//   Clk   : system clock, all state updates on posedge
//   reset : asynchronous active-low reset
//   bus   : requester/register bundle (see shared_reg_write_arbiter_if)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no owner; pick the first requester scanning from ptr
// GRANT   | gnt[owner] shown; abort if req[owner] drops, else sample data/clr
// WRITE   | one ce (write) or srst (clear) strobe plus done[owner]
// RELEASE | wait for req[owner] to drop so a held request is written only once
module shared_reg_write_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 16
) (
    input logic                        Clk,
    input logic                        reset,
    shared_reg_write_arbiter_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_WRITE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic           reg_ce_q, reg_ce_d;
    logic           reg_srst_q, reg_srst_d;
    logic [W-1:0]   reg_d_q, reg_d_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  xact_cnt_q, xact_cnt_d;

    logic [IW-1:0]  pick;
    logic           pick_vld;
    int             scan_idx;
    logic [W-1:0]   owner_data;
    logic           owner_clr;

    // Rotating priority scan: ptr has highest priority, then ptr+1, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (int'(ptr_q) + k) % N;
            if (!pick_vld && bus.req[scan_idx]) begin
                pick_vld = 1'b1;
                pick     = IW'(scan_idx);
            end
        end
    end

    assign owner_data = bus.wr_data[owner_q*W +: W];
    assign owner_clr  = bus.clr_req[owner_q];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        reg_ce_d   = 1'b0;
        reg_srst_d = 1'b0;
        reg_d_d    = reg_d_q;
        busy_d     = busy_q;
        xact_cnt_d = xact_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d     = S_GRANT;
                    owner_d     = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_GRANT: begin
                if (!bus.req[owner_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    // Outputs are registered, so the WRITE strobes are built
                    // here from the data/clr sampled at the end of GRANT.
                    state_d = S_WRITE;
                    done_d  = gnt_q;
                    if (owner_clr) begin
                        reg_srst_d = 1'b1;
                        reg_d_d    = '0;
                    end else begin
                        reg_ce_d   = 1'b1;
                        reg_d_d    = owner_data;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_RELEASE;
                gnt_d   = '0;
                ptr_d   = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
                if (xact_cnt_q != '1) begin
                    xact_cnt_d = xact_cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!bus.req[owner_q]) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            reg_ce_q   <= 1'b0;
            reg_srst_q <= 1'b0;
            reg_d_q    <= '0;
            busy_q     <= 1'b0;
            xact_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            reg_ce_q   <= reg_ce_d;
            reg_srst_q <= reg_srst_d;
            reg_d_q    <= reg_d_d;
            busy_q     <= busy_d;
            xact_cnt_q <= xact_cnt_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.reg_ce   = reg_ce_q;
    assign bus.reg_srst = reg_srst_q;
    assign bus.reg_d    = reg_d_q;
    assign bus.busy     = busy_q;
    assign bus.xact_cnt = xact_cnt_q;
endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
module tb_shared_reg_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 16;

    logic Clk   = 1'b0;
    logic reset = 1'b1;
    always #5 Clk = ~Clk;

    shared_reg_write_arbiter_if #(.N(N), .W(W), .CW(CW)) bus ();
    shared_reg_write_arbiter_if #(.N(N), .W(W), .CW(2))  bus2 ();

    shared_reg_write_arbiter #(.N(N), .W(W), .CW(CW)) dut (
        .Clk(Clk), .reset(reset), .bus(bus)
    );
    // Narrow-counter copy sees the same stimulus; only its counter is checked.
    shared_reg_write_arbiter #(.N(N), .W(W), .CW(2)) dut2 (
        .Clk(Clk), .reset(reset), .bus(bus2)
    );
    assign bus2.req     = bus.req;
    assign bus2.clr_req = bus.clr_req;
    assign bus2.wr_data = bus.wr_data;

    // Behavioural copy of the external register bank driven by the strobes.
    logic [W-1:0] shadow;
    always @(posedge Clk or negedge reset) begin
        if (!reset)              shadow <= '0;
        else if (bus.reg_srst)   shadow <= '0;
        else if (bus.reg_ce)     shadow <= bus.reg_d;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level reference model state.
    int           mdl_ptr = 0;
    int           exp_cnt = 0;
    logic [W-1:0] exp_reg = '0;
    logic [W-1:0] rd_data [N];
    logic         rd_clr  [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge Clk);
        check("ce_srst_excl", 32'(bus.reg_ce & bus.reg_srst), 0);
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
        check("done_without_gnt", 32'(bus.done & ~bus.gnt), 0);
    endtask

    task automatic check_release();
        check("rel_gnt", 32'(bus.gnt), 0);
        check("rel_done", 32'(bus.done), 0);
        check("rel_ce", 32'(bus.reg_ce), 0);
        check("rel_srst", 32'(bus.reg_srst), 0);
        check("rel_busy", 32'(bus.busy), 1);
    endtask

    task automatic check_counts();
        int sat;
        sat = (exp_cnt > 3) ? 3 : exp_cnt;
        check("xact_cnt", 32'(bus.xact_cnt), 32'(exp_cnt));
        check("xact_cnt_sat", 32'(bus2.xact_cnt), 32'(sat));
        check("shared_reg", 32'(shadow), 32'(exp_reg));
    endtask

    // Raise all requesters in mask (DUT idle) with rd_data/rd_clr, then serve
    // them; each holds req for hold_max-bounded random cycles after its done.
    task automatic run_round(input logic [N-1:0] mask, input int hold_max);
        int order [$];
        logic [N-1:0] pend;
        int p, o, waited, e;
        pend = mask;
        p = mdl_ptr;
        while (pend != 0) begin
            for (int k = 0; k < N; k++) begin
                if (pend[(p + k) % N]) begin
                    o = (p + k) % N;
                    break;
                end
            end
            order.push_back(o);
            pend[o] = 1'b0;
            p = (o + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                bus.wr_data[i*W +: W] = rd_data[i];
                bus.clr_req[i]        = rd_clr[i];
            end
        end
        bus.req = bus.req | mask;
        foreach (order[j]) begin
            o = order[j];
            waited = 0;
            do begin
                step();
                waited++;
            end while (bus.gnt == 0 && waited < 6);
            check("gnt_latency", 32'(waited), 1);
            check("gnt_owner", 32'(bus.gnt), 32'(1 << o));
            check("grant_done", 32'(bus.done), 0);
            check("grant_ce", 32'(bus.reg_ce), 0);
            check("grant_busy", 32'(bus.busy), 1);
            step();
            check("write_done", 32'(bus.done), 32'(1 << o));
            check("write_gnt", 32'(bus.gnt), 32'(1 << o));
            check("write_ce", 32'(bus.reg_ce), 32'(!rd_clr[o]));
            check("write_srst", 32'(bus.reg_srst), 32'(rd_clr[o]));
            check("write_d", 32'(bus.reg_d), rd_clr[o] ? 32'(0) : 32'(rd_data[o]));
            exp_reg = rd_clr[o] ? '0 : rd_data[o];
            exp_cnt++;
            mdl_ptr = (o + 1) % N;
            // Late changes must not affect the transaction already in flight.
            bus.wr_data[o*W +: W] = ~rd_data[o];
            bus.clr_req[o]        = ~rd_clr[o];
            e = (hold_max > 0) ? $urandom_range(0, hold_max) : 0;
            if (e == 0) bus.req[o] = 1'b0;
            step();
            check_release();
            for (int k = 1; k < e; k++) begin
                step();
                check_release();
            end
            if (e != 0) bus.req[o] = 1'b0;
            step();
            check("idle_busy", 32'(bus.busy), 0);
            check("idle_gnt", 32'(bus.gnt), 0);
            check_counts();
        end
    endtask

    task automatic do_reset();
        bus.req = '0;
        @(negedge Clk);
        #1 reset = 1'b0;
        step();
        reset = 1'b1;
        mdl_ptr = 0;
        exp_cnt = 0;
        exp_reg = '0;
    endtask

    initial begin
        bus.req     = '0;
        bus.clr_req = '0;
        bus.wr_data = '0;
        #2 reset = 1'b0;
        step();
        step();
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_ce", 32'(bus.reg_ce), 0);
        check("rst_srst", 32'(bus.reg_srst), 0);
        check("rst_d", 32'(bus.reg_d), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cnt", 32'(bus.xact_cnt), 0);
        reset = 1'b1;
        step();

        // Single write from requester 1.
        rd_data[1] = 8'hA5; rd_clr[1] = 1'b0;
        run_round(4'b0010, 0);

        // Clear from requester 2.
        rd_data[2] = 8'h3C; rd_clr[2] = 1'b1;
        run_round(4'b0100, 1);

        // Held request: 10 cycles of RELEASE with no further strobe.
        rd_data[0] = 8'h5A; rd_clr[0] = 1'b0;
        bus.wr_data[0 +: W] = rd_data[0];
        bus.clr_req[0]      = 1'b0;
        bus.req[0] = 1'b1;
        step();
        check("held_gnt", 32'(bus.gnt), 32'b0001);
        step();
        check("held_ce", 32'(bus.reg_ce), 1);
        exp_reg = rd_data[0]; exp_cnt++; mdl_ptr = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_release();
        end
        bus.req[0] = 1'b0;
        step();
        check("held_idle_busy", 32'(bus.busy), 0);
        check_counts();

        // Abort: requester 3 drops req during GRANT.
        bus.wr_data[3*W +: W] = 8'hEE;
        bus.clr_req[3]        = 1'b0;
        bus.req[3] = 1'b1;
        step();
        check("abort_gnt", 32'(bus.gnt), 32'b1000);
        bus.req[3] = 1'b0;
        step();
        check("abort_gnt_off", 32'(bus.gnt), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_ce", 32'(bus.reg_ce), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check_counts();
        // Scan must still start at 1: requester 3 wins over 0.
        rd_data[3] = 8'h81; rd_clr[3] = 1'b0;
        rd_data[0] = 8'h42; rd_clr[0] = 1'b0;
        run_round(4'b1001, 2);

        // Asynchronous reset in the middle of WRITE.
        bus.wr_data[2*W +: W] = 8'h77;
        bus.clr_req[2]        = 1'b0;
        bus.req[2] = 1'b1;
        step();
        step();
        check("mid_write_ce", 32'(bus.reg_ce), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_gnt", 32'(bus.gnt), 0);
        check("arst_done", 32'(bus.done), 0);
        check("arst_ce", 32'(bus.reg_ce), 0);
        check("arst_d", 32'(bus.reg_d), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_cnt", 32'(bus.xact_cnt), 0);
        check("arst_cnt_sat", 32'(bus2.xact_cnt), 0);
        bus.req = '0;
        step();
        check("arst_hold_ce", 32'(bus.reg_ce), 0);
        reset = 1'b1;
        mdl_ptr = 0; exp_cnt = 0; exp_reg = '0;

        // Fairness from ptr 0: 0,1,2,3 then 0; narrow counter saturates.
        for (int i = 0; i < N; i++) begin
            rd_data[i] = 8'(8'h10 + i);
            rd_clr[i]  = 1'b0;
        end
        run_round(4'b1111, 1);
        rd_data[0] = 8'hC3;
        run_round(4'b0001, 0);
        check("fair_cnt", 32'(bus.xact_cnt), 5);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                rd_data[i] = 8'($urandom);
                rd_clr[i]  = ($urandom_range(0, 3) == 0);
            end
            run_round(m, 3);
        end

        do_reset();
        check("final_cnt", 32'(bus.xact_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/shared_reg_write_arbiter.md
Name: shared_reg_write_arbiter

Overview:
- Round-robin arbiter and sequencer giving N requesters exclusive write or clear access to one shared W-bit register.
- The shared register is an external bank of D flip-flops with clock enable and synchronous reset.
- This block drives the register's ce, synchronous-reset and D inputs through a fixed grant/write/release sequence, so only one requester modifies the register per transaction.
- It also keeps a saturating count of completed writes.

Parameters:
- N, 4: number of requesters (2..8).
- W, 8: data width of the shared register.
- CW, 16: width of the completed-transaction counter.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  N  per-requester access request; level, held until done seen.
- clr_req  input  N  per-requester: 1 = clear register, 0 = write data; sampled with data.
- wr_data  input  N*W  packed write data; requester i at bits [i*W +: W].
- gnt  output  N  one-hot grant; all-zero when idle.
- done  output  N  one-cycle completion pulse to the granted requester.
- reg_ce  output  1  clock enable to the shared register.
- reg_srst  output  1  synchronous reset to the shared register.
- reg_d  output  W  data to the shared register.
- busy  output  1  high in any state other than IDLE.
- xact_cnt  output  CW  completed transactions, saturating at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, gnt=0, done=0, reg_ce=0, reg_srst=0, reg_d=0, busy=0, xact_cnt=0, priority pointer ptr=0, captured owner/data/clr cleared. Reset mid-transaction aborts it; no ce/srst pulse escapes.
- States: IDLE, GRANT, WRITE, RELEASE. All outputs are registered.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Record owner index; next state is GRANT.
- GRANT (1 cycle):
  - gnt[owner]=1, busy=1.
  - Capture wr_data[owner] and clr_req[owner] at the end of this cycle.
  - If req[owner]=0 in this cycle: abort to IDLE. No write, no done, ptr unchanged, xact_cnt unchanged.
- WRITE (1 cycle):
  - gnt[owner]=1, done[owner]=1.
  - If captured clr=1: reg_srst=1, reg_ce=0, reg_d=0.
  - Otherwise: reg_ce=1, reg_srst=0, reg_d=captured data.
  - ptr <= (owner+1) mod N; xact_cnt increments unless already all-ones.
- RELEASE:
  - gnt=0, reg_ce=0, reg_srst=0, reg_d holds its last value.
  - Stay while req[owner]=1, so a held request cannot be written twice.
  - Go to IDLE the cycle after req[owner]=0.
- Latency: req rising in IDLE at cycle t gives gnt at t+1 and the ce/srst pulse plus done at t+2. Minimum back-to-back transactions are 4 cycles apart (IDLE, GRANT, WRITE, RELEASE).
- Requests from non-owners are ignored while busy; they stay pending (requester holds req) and are arbitrated on the next IDLE.
- reg_ce and reg_srst are never both 1. gnt is never more than one-hot. done is asserted only in WRITE.
- Changes to wr_data or clr_req after GRANT have no effect on the current transaction.
- With N=1 the pointer stays 0.

Test Plan:
- Reset then single write: req=4'b0010, wr_data[1]=8'hA5, clr_req=0 → gnt=0010 at t+1; reg_ce=1, reg_d=A5, done=0010 at t+2; xact_cnt=1; gnt=0 at t+3.
- Clear: req[2]=1, clr_req[2]=1 → at t+2 reg_srst=1, reg_ce=0, done[2]=1; never both strobes high.
- Round-robin fairness: req=4'b1111 held, each requester dropping req after its done → grants in order 0,1,2,3,0; xact_cnt=5.
- Held request: req[0] stays 1 for 10 cycles after done → exactly one reg_ce pulse; FSM stays in RELEASE; then IDLE the cycle after req[0] drops.
- Abort and async reset:
  - req[3] dropped during GRANT → no reg_ce, no done, ptr unchanged, next grant from the same scan start.
  - reset=0 asserted mid-WRITE → all outputs 0 immediately, xact_cnt=0.
- Saturation with CW=2: 5 transactions → xact_cnt=2'b11 after the 3rd and stays there.
